// File: rtl/tff_down_counter.sv
// -----------------------------------------------------------------------------
// tff_down_counter
//
// Loadable, parameterized binary down-counter clocked on the falling edge of
// clk. Counts from a loaded start value to zero, pulses underflow when the
// count wraps out of zero, and either stops (one-shot) or reloads the captured
// start value and keeps running (periodic timer / divider).
//
// Handshake/strobe semantics: load and en are level-sampled strobes. Whatever
// value they hold at a falling clk edge takes effect at that edge; there is no
// back-pressure. load has priority over counting, and en is ignored on a load
// edge.
//
// Ports:
//   clk          in   1      counter clock, all state changes on negedge
//   reset        in   1      asynchronous active-low reset
//   load         in   1      synchronous load strobe
//   load_val     in   WIDTH  start/reload value captured on load
//   en           in   1      count enable
//   auto_reload  in   1      1 = reload at underflow, 0 = stop at underflow
//   count_out    out  WIDTH  registered counter value
//   zero         out  1      combinational, count_out == 0
//   underflow    out  1      registered one-cycle wrap pulse
//   busy         out  1      FSM state: 1 while RUN, 0 while IDLE
// -----------------------------------------------------------------------------
module tff_down_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count_out,
    output logic             zero,
    output logic             underflow,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   reload_q, reload_d;
    logic               underflow_q, underflow_d;

    // State register: falling-edge clocked, asynchronous active-low clear.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            reload_q    <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            reload_q    <= reload_d;
            underflow_q <= underflow_d;
        end
    end

    // Next-state logic. Priority: load > count. The underflow pulse only
    // exists on a wrap edge, so it defaults low every other edge.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        reload_d    = reload_q;
        underflow_d = 1'b0;

        if (load) begin
            reload_d = load_val;
            count_d  = load_val;
            // A zero start value has nothing to count, so it parks in IDLE.
            state_d  = (load_val != '0) ? RUN : IDLE;
        end else if (state_q == RUN && en) begin
            if (count_q != '0) begin
                count_d = count_q - WIDTH'(1);
            end else begin
                // Wrap out of zero: auto_reload is only consulted here.
                underflow_d = 1'b1;
                if (auto_reload) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = IDLE;
                end
            end
        end
    end

    // Output logic.
    always_comb begin
        count_out = count_q;
        zero      = (count_q == '0);
        underflow = underflow_q;
        busy      = (state_q == RUN);
    end

endmodule
